fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the CPU core.
- Owns the PC register and the sequential PC+4 next-PC adder.
- Fetches from instruction memory over a variable-latency req/ack handshake and buffers fetched instructions in a small prefetch FIFO.
- Accepts branch/jump redirects from the execute stage, flushing stale fetches.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory req/ack handshake, redirect input
// and the instruction stream handed to decode.
interface fetch_unit_if #(
    parameter int AW = 32
);
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_ack;
    logic [31:0]   im_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic [AW-1:0] inst_npc;
    logic          inst_ready;

    modport master (
        output im_req, im_addr, inst_valid, inst, inst_pc, inst_npc,
        input  im_ack, im_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  im_req, im_addr, inst_valid, inst, inst_pc, inst_npc,
        output im_ack, im_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, one-outstanding req/ack fetch
// engine and a small prefetch FIFO with redirect flush.
module fetch_unit #(
    parameter int          AW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);
    localparam logic [AW-1:0] STEP       = AW'(4);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // DROP: a request is still outstanding but its data belongs to a
    // flushed path and will be discarded when it returns.
    typedef enum logic [1:0] {REQ, DROP, FULL} state_t;

    state_t        state, state_next;
    logic [AW-1:0] fetch_pc, fetch_pc_next;
    logic          req_q;
    logic [AW-1:0] addr_q, addr_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic          ack, pop, push, flush;
    logic [AW-1:0] target;
    logic          unused_pc_bits;

    assign ack            = bus.im_ack & req_q;
    assign pop            = (count != '0) & bus.inst_ready;
    assign flush          = bus.redirect;
    assign push           = ack & (state == REQ) & ~bus.redirect;
    assign target         = {bus.redirect_pc[AW-1:2], 2'b00};
    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        count_next    = flush ? '0 : count + CW'(push) - CW'(pop);

        unique case (state)
            REQ: begin
                if (bus.redirect) begin
                    fetch_pc_next = target;
                    state_next    = ack ? REQ : DROP;
                end else if (ack) begin
                    fetch_pc_next = fetch_pc + STEP;
                    state_next    = (count_next == FULL_COUNT) ? FULL : REQ;
                end
            end
            DROP: begin
                if (bus.redirect) fetch_pc_next = target;
                if (ack)          state_next    = REQ;
            end
            FULL: begin
                if (bus.redirect) begin
                    fetch_pc_next = target;
                    state_next    = REQ;
                end else if (pop) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase

        // The stale request keeps its address on the bus until it is acked.
        addr_next = (state_next == DROP) ? addr_q : fetch_pc_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= REQ;
            fetch_pc <= RESET_ADDR;
            req_q    <= 1'b1;
            addr_q   <= RESET_ADDR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_q    <= (state_next != FULL);
            addr_q   <= addr_next;
            count    <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the count qualifies
    // every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.im_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    assign bus.im_req     = req_q;
    assign bus.im_addr    = addr_q;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = bus.inst_valid ? inst_mem[rd_ptr] : '0;
    assign bus.inst_pc    = bus.inst_valid ? pc_mem[rd_ptr]   : '0;
    assign bus.inst_npc   = bus.inst_pc + STEP;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (reset PC 0 and near the top of the
// address space), a latency-programmable memory, a queue model and directed checks.
module tb_fetch_unit;
    localparam int          AW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_s [2];
    logic        ack_s   [2];
    logic [31:0] rdata_s [2];
    logic        redir_s [2];
    logic [31:0] rpc_s   [2];
    logic        ready_s [2];
    int          lat_s   [2];

    logic        req_o   [2];
    logic [31:0] addr_o  [2];
    logic        valid_o [2];
    logic [31:0] inst_o  [2];
    logic [31:0] pc_o    [2];
    logic [31:0] npc_o   [2];

    int n_vec = 0;
    int n_bad = 0;

    fetch_unit_if #(.AW(AW)) bus0 ();
    fetch_unit_if #(.AW(AW)) bus1 ();

    fetch_unit #(.AW(AW), .RESET_PC(RPC0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset_s[0]), .bus(bus0)
    );
    fetch_unit #(.AW(AW), .RESET_PC(RPC1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset_s[1]), .bus(bus1)
    );

    assign bus0.im_ack      = ack_s[0];
    assign bus0.im_rdata    = rdata_s[0];
    assign bus0.redirect    = redir_s[0];
    assign bus0.redirect_pc = rpc_s[0];
    assign bus0.inst_ready  = ready_s[0];
    assign bus1.im_ack      = ack_s[1];
    assign bus1.im_rdata    = rdata_s[1];
    assign bus1.redirect    = redir_s[1];
    assign bus1.redirect_pc = rpc_s[1];
    assign bus1.inst_ready  = ready_s[1];

    assign req_o[0]   = bus0.im_req;
    assign addr_o[0]  = bus0.im_addr;
    assign valid_o[0] = bus0.inst_valid;
    assign inst_o[0]  = bus0.inst;
    assign pc_o[0]    = bus0.inst_pc;
    assign npc_o[0]   = bus0.inst_npc;
    assign req_o[1]   = bus1.im_req;
    assign addr_o[1]  = bus1.im_addr;
    assign valid_o[1] = bus1.inst_valid;
    assign inst_o[1]  = bus1.inst;
    assign pc_o[1]    = bus1.inst_pc;
    assign npc_o[1]   = bus1.inst_npc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Memory: ack on the lat-th cycle a request has been up, data = addr ^ SALT.
    int n_wait [2];
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (reset_s[d] || !req_o[d]) begin
                ack_s[d]  = 1'b0;
                n_wait[d] = 0;
            end else begin
                n_wait[d]++;
                if (n_wait[d] >= lat_s[d]) begin
                    ack_s[d]   = 1'b1;
                    rdata_s[d] = addr_o[d] ^ SALT;
                    n_wait[d]  = 0;
                end else begin
                    ack_s[d] = 1'b0;
                end
            end
        end
    end

    // Model: an ordered list of fetched words, the next fetch address and an
    // optional stale outstanding address. A request is up whenever the list
    // has room; pending data from an abandoned path is thrown away.
    logic [31:0] m_pc    [2];
    logic [31:0] m_saddr [2];
    logic        m_stale [2];
    int          m_cnt   [2];
    logic [31:0] m_inst  [2][DEPTH];
    logic [31:0] m_ipc   [2][DEPTH];

    function automatic logic exp_req(input int d);
        return m_cnt[d] != DEPTH;
    endfunction

    function automatic logic [31:0] exp_addr(input int d);
        return m_stale[d] ? m_saddr[d] : m_pc[d];
    endfunction

    function automatic void model_step(input int d);
        logic        req, a, take;
        logic [31:0] addr;
        req  = exp_req(d);
        addr = exp_addr(d);
        a    = ack_s[d] && req;
        take = (m_cnt[d] > 0) && ready_s[d];
        if (redir_s[d]) begin
            m_stale[d] = req && !a;
            m_saddr[d] = addr;
            m_cnt[d]   = 0;
            m_pc[d]    = rpc_s[d] & ~32'h3;
        end else if (m_stale[d]) begin
            if (a) m_stale[d] = 1'b0;
        end else begin
            if (take) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    m_inst[d][i] = m_inst[d][i+1];
                    m_ipc[d][i]  = m_ipc[d][i+1];
                end
                m_cnt[d]--;
            end
            if (a) begin
                m_inst[d][m_cnt[d]] = rdata_s[d];
                m_ipc[d][m_cnt[d]]  = m_pc[d];
                m_cnt[d]++;
                m_pc[d] = m_pc[d] + 32'd4;
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset_s[d]) begin
                m_pc[d]    = (d == 0) ? RPC0 : RPC1;
                m_saddr[d] = 32'd0;
                m_stale[d] = 1'b0;
                m_cnt[d]   = 0;
            end else begin
                model_step(d);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_s[d]) begin
                check_bit($sformatf("d%0d im_req", d), req_o[d], exp_req(d));
                check($sformatf("d%0d im_addr", d), addr_o[d], exp_addr(d));
                check_bit($sformatf("d%0d inst_valid", d), valid_o[d], m_cnt[d] != 0);
                if (m_cnt[d] != 0) begin
                    check($sformatf("d%0d inst", d), inst_o[d], m_inst[d][0]);
                    check($sformatf("d%0d inst_pc", d), pc_o[d], m_ipc[d][0]);
                    check($sformatf("d%0d inst_npc", d), npc_o[d], m_ipc[d][0] + 32'd4);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete, got no end, want end");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_s[d] = 1'b1;
            ack_s[d]   = 1'b0;
            rdata_s[d] = 32'd0;
            redir_s[d] = 1'b0;
            rpc_s[d]   = 32'd0;
            ready_s[d] = 1'b1;
            lat_s[d]   = 1;
            n_wait[d]  = 0;
        end
        repeat (2) cyc();
        check_bit("rst inst_valid", valid_o[0], 1'b0);
        check("rst inst", inst_o[0], 32'h0);
        check("rst inst_pc", pc_o[0], 32'h0);
        check_bit("rst im_req", req_o[0], 1'b1);
        check("rst im_addr", addr_o[0], 32'h0);
        #2 reset_s[0] = 1'b0;

        // 1-cycle memory, consumer always ready.
        cyc();
        check("seq addr 0", addr_o[0], 32'h0);
        check_bit("no valid before ack", valid_o[0], 1'b0);
        cyc();
        check("seq addr 4", addr_o[0], 32'h4);
        check_bit("first valid", valid_o[0], 1'b1);
        check("first inst_pc", pc_o[0], 32'h0);
        check("first inst", inst_o[0], 32'hA5A5_0000);
        check("first inst_npc", npc_o[0], 32'h4);
        cyc();
        check("seq addr 8", addr_o[0], 32'h8);
        check("seq inst_pc 4", pc_o[0], 32'h4);
        cyc();
        check("seq addr C", addr_o[0], 32'hC);
        ready_s[0] = 1'b0;

        // Back-pressure fills the FIFO; one pop restarts fetching.
        cyc();
        check_bit("full im_req", req_o[0], 1'b0);
        check("full head", pc_o[0], 32'h8);
        ready_s[0] = 1'b1;
        cyc();
        check_bit("refetch im_req", req_o[0], 1'b1);
        check("refetch im_addr", addr_o[0], 32'h10);
        check("after pop head", pc_o[0], 32'hC);
        ready_s[0] = 1'b0;
        cyc();
        check_bit("full again", req_o[0], 1'b0);
        ready_s[0] = 1'b1;
        lat_s[0]   = 3;

        // 3-cycle memory latency holds the address.
        cyc();
        check("lat3 addr c1", addr_o[0], 32'h14);
        check("drain head 10", pc_o[0], 32'h10);
        cyc();
        check("lat3 addr c2", addr_o[0], 32'h14);
        check_bit("drained", valid_o[0], 1'b0);
        cyc();
        check("lat3 addr c3", addr_o[0], 32'h14);
        cyc();
        check_bit("lat3 valid", valid_o[0], 1'b1);
        check("lat3 inst_pc", pc_o[0], 32'h14);
        check("lat3 inst", inst_o[0], 32'hA5A5_0014);
        check("lat3 next addr", addr_o[0], 32'h18);
        lat_s[0] = 100;

        // Redirect while the request for 18 is pending.
        cyc();
        check("pending addr 18", addr_o[0], 32'h18);
        redir_s[0] = 1'b1;
        rpc_s[0]   = 32'h0000_0100;
        cyc();
        redir_s[0] = 1'b0;
        check("drop keeps addr", addr_o[0], 32'h18);
        check_bit("drop im_req", req_o[0], 1'b1);
        check_bit("drop flushed", valid_o[0], 1'b0);
        lat_s[0] = 1;
        cyc();
        check("drop still addr", addr_o[0], 32'h18);
        cyc();
        check("redirect addr", addr_o[0], 32'h100);
        check_bit("stale dropped", valid_o[0], 1'b0);
        cyc();
        check("redirect inst_pc", pc_o[0], 32'h100);
        check("redirect inst", inst_o[0], 32'hA5A5_0100);
        ready_s[0] = 1'b0;

        // Redirect in FULL with a concurrent pop; low address bits ignored.
        cyc();
        check_bit("full before redirect", req_o[0], 1'b0);
        redir_s[0] = 1'b1;
        rpc_s[0]   = 32'h0000_0203;
        ready_s[0] = 1'b1;
        cyc();
        redir_s[0] = 1'b0;
        check_bit("full redirect flush", valid_o[0], 1'b0);
        check_bit("full redirect req", req_o[0], 1'b1);
        check("full redirect addr", addr_o[0], 32'h200);

        // Mixed latency, back-pressure and redirect pattern, model-checked.
        for (int i = 0; i < 80; i++) begin
            cyc();
            ready_s[0] = (i % 3) != 2;
            redir_s[0] = (i % 11 == 5) || (i % 13 == 9);
            rpc_s[0]   = 32'h1000 + 32'(i) * 32'h24 + 32'(i % 4);
            lat_s[0]   = 1 + (i / 8) % 4;
        end
        cyc();
        redir_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        lat_s[0]   = 1;

        // Second instance: address wrap and asynchronous reset mid-stream.
        #2 reset_s[1] = 1'b0;
        cyc();
        check("wrap addr FFF8", addr_o[1], 32'hFFFF_FFF8);
        cyc();
        check("wrap addr FFFC", addr_o[1], 32'hFFFF_FFFC);
        check("wrap head FFF8", pc_o[1], 32'hFFFF_FFF8);
        cyc();
        check("wrap addr 0", addr_o[1], 32'h0);
        check("wrap head FFFC", pc_o[1], 32'hFFFF_FFFC);
        check("wrap npc", npc_o[1], 32'h0);
        cyc();
        check("wrap addr 4", addr_o[1], 32'h4);
        check("wrap head 0", pc_o[1], 32'h0);
        cyc();
        #2 reset_s[1] = 1'b1;
        #1;
        check_bit("async rst valid", valid_o[1], 1'b0);
        check("async rst addr", addr_o[1], 32'hFFFF_FFF8);
        check_bit("async rst req", req_o[1], 1'b1);
        cyc();
        cyc();
        #2 reset_s[1] = 1'b0;
        cyc();
        check("post rst addr", addr_o[1], 32'hFFFF_FFF8);
        check_bit("post rst empty", valid_o[1], 1'b0);
        cyc();
        check("post rst head", pc_o[1], 32'hFFFF_FFF8);
        check("post rst inst", inst_o[1], 32'h5A5A_FFF8);
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
